// File: rtl/tm_host_driver.sv
// tm_host_driver: host-side load/step sequencer for the Turing machine.
// Presents head position, pulses each tape word, then drives step strobes.
module tm_host_driver #(
  parameter int DW        = 4,
  parameter int HOLD      = 2,
  parameter int GAP       = 2,
  parameter int SW        = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          start,
  input  logic [DW-1:0] head_pos,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          auto_run,
  input  logic          step_req,
  input  logic          Compute_done,
  output logic [DW-1:0] input_data,
  output logic          Next,
  output logic          Done,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [SW-1:0] step_count
);

  localparam int MX = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW = $clog2(MX + 1);

  localparam logic [TW-1:0] HOLD_T = TW'(HOLD - 1);
  localparam logic [TW-1:0] GAP_T  = TW'(GAP - 1);
  localparam logic [SW-1:0] MAX_C  = SW'(MAX_STEPS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_FETCH,
    S_PULSE_HI,
    S_PULSE_LO,
    S_DONE,
    S_RUN_WAIT,
    S_STEP_HI,
    S_STEP_LO,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [DW-1:0] word_q, word_d;
  logic          last_q, last_d;
  logic [SW-1:0] cnt_q, cnt_d;

  logic          tmr_zero;
  logic [TW-1:0] tmr_dec;

  assign tmr_zero = (tmr_q == '0);
  assign tmr_dec  = tmr_q - TW'(1);

  // State, shared phase timer, latched word/last and step counter.
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the timer is reloaded whenever a timed state is entered.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    word_d  = word_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          word_d  = head_pos;
          cnt_d   = '0;
          tmr_d   = GAP_T;
        end
      end
      S_SETUP: begin
        if (tmr_zero) state_d = S_FETCH;
        else          tmr_d   = tmr_dec;
      end
      S_FETCH: begin
        if (s_valid) begin
          state_d = S_PULSE_HI;
          word_d  = s_data;
          last_d  = s_last;
          tmr_d   = HOLD_T;
        end
      end
      S_PULSE_HI: begin
        if (tmr_zero) begin
          state_d = S_PULSE_LO;
          tmr_d   = GAP_T;
        end else begin
          tmr_d   = tmr_dec;
        end
      end
      S_PULSE_LO: begin
        if (tmr_zero) state_d = last_q ? S_DONE : S_FETCH;
        else          tmr_d   = tmr_dec;
      end
      S_DONE: begin
        state_d = S_RUN_WAIT;
      end
      S_RUN_WAIT: begin
        if (Compute_done) begin
          state_d = S_HALTED;
        end else if (cnt_q == MAX_C) begin
          state_d = S_TIMEOUT;
        end else if (auto_run || step_req) begin
          state_d = S_STEP_HI;
          tmr_d   = HOLD_T;
        end
      end
      S_STEP_HI: begin
        if (tmr_zero) begin
          state_d = S_STEP_LO;
          tmr_d   = GAP_T;
        end else begin
          tmr_d   = tmr_dec;
        end
      end
      S_STEP_LO: begin
        if (tmr_zero) begin
          state_d = S_RUN_WAIT;
          cnt_d   = cnt_q + SW'(1);
        end else begin
          tmr_d   = tmr_dec;
        end
      end
      S_HALTED:  state_d = S_HALTED;
      S_TIMEOUT: state_d = S_TIMEOUT;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decode the registered state only.
  always_comb begin
    s_ready    = (state_q == S_FETCH);
    Next       = (state_q == S_PULSE_HI) || (state_q == S_STEP_HI);
    Done       = (state_q == S_DONE);
    finished   = (state_q == S_HALTED);
    timeout    = (state_q == S_TIMEOUT);
    busy       = !((state_q == S_IDLE) || (state_q == S_HALTED) ||
                   (state_q == S_TIMEOUT));
    step_count = cnt_q;
    input_data = '0;
    if ((state_q == S_SETUP) || (state_q == S_FETCH) ||
        (state_q == S_PULSE_HI) || (state_q == S_PULSE_LO))
      input_data = word_q;
  end

endmodule

// File: tb/tb_tm_host_driver.sv
// tb_tm_host_driver: randomized load/run sessions against a timeline model.
// Expected cycle-by-cycle outputs are built from the protocol timing rules.
module tb_tm_host_driver;

  localparam int DW   = 4;
  localparam int HOLD = 2;
  localparam int GAP  = 2;
  localparam int SW   = 8;
  localparam int MAXS = 4;
  localparam int EW   = DW + 6 + SW;
  localparam int NX   = SW + 5;
  localparam int DN   = SW + 4;
  localparam int RDY  = SW + 3;
  localparam int BZ   = SW + 2;
  localparam int FIN  = SW + 1;
  localparam int TO   = SW;

  logic          clock = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] head_pos = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          auto_run = 1'b0;
  logic          step_req = 1'b0;
  logic          Compute_done = 1'b0;
  logic [DW-1:0] input_data;
  logic          Next;
  logic          Done;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [SW-1:0] step_count;

  always #5 clock = ~clock;

  tm_host_driver #(
    .DW(DW), .HOLD(HOLD), .GAP(GAP), .SW(SW), .MAX_STEPS(MAXS)
  ) dut (
    .clock(clock), .Reset(Reset), .start(start), .head_pos(head_pos),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .auto_run(auto_run), .step_req(step_req),
    .Compute_done(Compute_done), .input_data(input_data), .Next(Next),
    .Done(Done), .busy(busy), .finished(finished), .timeout(timeout),
    .step_count(step_count)
  );

  typedef struct {
    logic          st;
    logic [DW-1:0] hp;
    logic          sv;
    logic [DW-1:0] sd;
    logic          sl;
    logic          ar;
    logic          sr;
    logic          cd;
    logic [EW-1:0] ex;
  } cyc_t;

  cyc_t          tl[$];
  logic [EW-1:0] obs[$];
  logic [DW-1:0] wq[$];
  int            sq[$];
  int            tests = 0;
  int            fails = 0;
  int            cnt_m = 0;
  logic [DW-1:0] cur_id = '0;
  bit            mode_ar = 1'b0;

  // one cycle: random don't-care inputs, given expected outputs
  function automatic cyc_t mk(logic [DW-1:0] id, bit nx, bit dn, bit rdy,
                              bit bz, bit fin, bit to);
    cyc_t c;
    c.st = 1'($urandom);
    c.hp = DW'($urandom);
    c.sv = 1'($urandom);
    c.sd = DW'($urandom);
    c.sl = 1'($urandom);
    c.ar = mode_ar;
    c.sr = 1'($urandom);
    c.cd = 1'($urandom);
    c.ex = {id, nx, dn, rdy, bz, fin, to, SW'(cnt_m)};
    return c;
  endfunction

  function automatic void m_start(logic [DW-1:0] hp);
    cyc_t c;
    c = mk('0, 0, 0, 0, 0, 0, 0);
    c.st = 1'b1;
    c.hp = hp;
    tl.push_back(c);
    cnt_m = 0;
    cur_id = hp;
    for (int g = 0; g < GAP; g++) tl.push_back(mk(hp, 0, 0, 0, 1, 0, 0));
  endfunction

  function automatic void m_word(logic [DW-1:0] w, bit last, int stall);
    cyc_t c;
    for (int k = 0; k < stall; k++) begin
      c = mk(cur_id, 0, 0, 1, 1, 0, 0);
      c.sv = 1'b0;
      tl.push_back(c);
    end
    c = mk(cur_id, 0, 0, 1, 1, 0, 0);
    c.sv = 1'b1;
    c.sd = w;
    c.sl = last;
    tl.push_back(c);
    cur_id = w;
    for (int h = 0; h < HOLD; h++) tl.push_back(mk(w, 1, 0, 0, 1, 0, 0));
    for (int g = 0; g < GAP; g++) tl.push_back(mk(w, 0, 0, 0, 1, 0, 0));
  endfunction

  function automatic void m_load(logic [DW-1:0] hp);
    m_start(hp);
    foreach (wq[i]) m_word(wq[i], i == wq.size() - 1, sq[i]);
    tl.push_back(mk('0, 0, 1, 0, 1, 0, 0));
  endfunction

  function automatic void m_rw(bit sr, bit cd);
    cyc_t c;
    c = mk('0, 0, 0, 0, 1, 0, 0);
    c.sr = sr;
    c.cd = cd;
    tl.push_back(c);
  endfunction

  function automatic void m_step(bit cd_hi, bit extra);
    cyc_t c;
    for (int h = 0; h < HOLD; h++) begin
      c = mk('0, 1, 0, 0, 1, 0, 0);
      if (cd_hi && h > 0) c.cd = 1'b1;
      tl.push_back(c);
    end
    for (int g = 0; g < GAP; g++) begin
      c = mk('0, 0, 0, 0, 1, 0, 0);
      if (cd_hi) c.cd = 1'b1;
      if (extra && g == GAP - 1) c.sr = 1'b1;
      tl.push_back(c);
    end
    cnt_m++;
  endfunction

  function automatic void m_end(bit halted);
    cyc_t c;
    for (int k = 0; k < 6; k++) begin
      c = mk('0, 0, 0, 0, 0, halted, !halted);
      if (!halted) c.cd = 1'b1;
      tl.push_back(c);
    end
  endfunction

  // continuous stepping: completion beats budget, budget beats stepping
  function automatic void m_auto(int halt_at);
    for (int k = 0; k <= MAXS; k++) begin
      if (cnt_m == halt_at) begin
        m_rw(1'($urandom), 1'b1);
        m_end(1'b1);
        return;
      end
      if (cnt_m == MAXS) begin
        m_rw(1'($urandom), 1'b0);
        m_end(1'b0);
        return;
      end
      m_rw(1'($urandom), 1'b0);
      m_step(cnt_m + 1 == halt_at, 1'b0);
    end
  endfunction

  function automatic void rnd_words(int n, int maxst);
    wq.delete();
    sq.delete();
    for (int i = 0; i < n; i++) begin
      wq.push_back(DW'($urandom));
      sq.push_back(int'($urandom_range(maxst, 0)));
    end
  endfunction

  function automatic int pulses(int from);
    int n = 0;
    for (int i = from + 1; i < obs.size(); i++)
      if (obs[i][NX] === 1'b1 && obs[i-1][NX] === 1'b0) n++;
    return n;
  endfunction

  function automatic int done_at();
    for (int i = 0; i < obs.size(); i++)
      if (obs[i][DN] === 1'b1) return i;
    return -1;
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    step_req = 1'b0;
    Compute_done = 1'b0;
    repeat (2) @(posedge clock);
    #1 Reset = 1'b0;
    @(posedge clock);
    #1;
    cnt_m = 0;
    tl.delete();
  endtask

  task automatic play();
    obs.delete();
    foreach (tl[i]) begin
      start = tl[i].st;
      head_pos = tl[i].hp;
      s_valid = tl[i].sv;
      s_data = tl[i].sd;
      s_last = tl[i].sl;
      auto_run = tl[i].ar;
      step_req = tl[i].sr;
      Compute_done = tl[i].cd;
      @(negedge clock);
      obs.push_back({input_data, Next, Done, s_ready, busy, finished,
                     timeout, step_count});
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    s_valid = 1'b0;
    step_req = 1'b0;
    Compute_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW-1:0] o;
    Reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    o = {input_data, Next, Done, s_ready, busy, finished, timeout, step_count};
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", o, {EW{1'b0}});
    end
    #1 Reset = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b1;
    head_pos = DW'($urandom);
    s_valid = 1'b1;
    s_data = DW'($urandom);
    s_last = 1'b0;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 0; k < 40 && Next !== 1'b1; k++) begin
      @(posedge clock);
      #1;
    end
    tests++;
    if (Next !== 1'b1) begin
      fails++;
      $display("FAIL rst_reach_pulse: Next=%b want 1", Next);
    end
    #2 Reset = 1'b1;
    #1;
    tests++;
    if ({Next, Done, busy, s_ready} !== 4'b0) begin
      fails++;
      $display("FAIL rst_async: N/D/busy/rdy=%b want 0000",
               {Next, Done, busy, s_ready});
    end
    @(posedge clock);
    #1 Reset = 1'b0;
    s_valid = 1'b0;
    @(negedge clock);
    o = {input_data, Next, Done, s_ready, busy, finished, timeout, step_count};
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL rst_release: got %h want %h", o, {EW{1'b0}});
    end
    @(posedge clock);
    #1;
    mode_ar = 1'b0;
    cnt_m = 0;
    tl.delete();
    rnd_words(1, 2);
    m_load(DW'($urandom));
    repeat (3) m_rw(1'b0, 1'b0);
    play();
    foreach (tl[i]) begin
      tests++;
      if (obs[i] !== tl[i].ex) begin
        fails++;
        $display("FAIL rst_session cyc %0d: got %h want %h", i, obs[i],
                 tl[i].ex);
      end
    end
  endtask

  task automatic test_three_word();
    int di;
    do_reset();
    mode_ar = 1'b0;
    wq = '{4'd1, 4'd2, 4'd3};
    sq = '{0, 0, 0};
    m_load(4'd5);
    repeat (4) m_rw(1'b0, 1'b0);
    foreach (tl[i]) tl[i].sv = 1'b1;
    play();
    foreach (tl[i]) begin
      tests++;
      if (obs[i] !== tl[i].ex) begin
        fails++;
        $display("FAIL three_word cyc %0d: got %h want %h", i, obs[i],
                 tl[i].ex);
      end
    end
    di = done_at();
    tests++;
    if (di != 1 + GAP + 3 * (1 + HOLD + GAP)) begin
      fails++;
      $display("FAIL three_word_done_pos: cycle %0d want %0d", di,
               1 + GAP + 3 * (1 + HOLD + GAP));
    end
    tests++;
    if (di >= 0 && obs[di+1][DN] !== 1'b0) begin
      fails++;
      $display("FAIL three_word_done_width: Done still %b want 0",
               obs[di+1][DN]);
    end
  endtask

  task automatic test_stream_stall();
    int  base;
    bit  ok;
    do_reset();
    mode_ar = 1'b0;
    rnd_words(3, 0);
    sq[1] = 7;
    m_load(DW'($urandom));
    repeat (3) m_rw(1'b0, 1'b0);
    play();
    foreach (tl[i]) begin
      tests++;
      if (obs[i] !== tl[i].ex) begin
        fails++;
        $display("FAIL stall cyc %0d: got %h want %h", i, obs[i], tl[i].ex);
      end
    end
    base = 1 + GAP + (1 + HOLD + GAP);
    ok = 1'b1;
    for (int k = 0; k < 7; k++)
      if (obs[base+k][RDY] !== 1'b1 || obs[base+k][NX] !== 1'b0) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL stall_window: rdy/next wrong in cycles %0d..%0d",
               base, base + 6);
    end
  endtask

  task automatic test_auto_halt();
    int last;
    do_reset();
    mode_ar = 1'b1;
    rnd_words(int'($urandom_range(3, 1)), 3);
    m_load(DW'($urandom));
    m_auto(4);
    play();
    foreach (tl[i]) begin
      tests++;
      if (obs[i] !== tl[i].ex) begin
        fails++;
        $display("FAIL auto_halt cyc %0d: got %h want %h", i, obs[i],
                 tl[i].ex);
      end
    end
    last = obs.size() - 1;
    tests++;
    if (obs[last][SW-1:0] !== SW'(4) || obs[last][FIN] !== 1'b1) begin
      fails++;
      $display("FAIL auto_halt_final: count=%0d fin=%b want 4 1",
               obs[last][SW-1:0], obs[last][FIN]);
    end
    tests++;
    if (pulses(done_at()) != 4) begin
      fails++;
      $display("FAIL auto_halt_pulses: got %0d want 4", pulses(done_at()));
    end
  endtask

  task automatic test_single_step();
    int last;
    do_reset();
    mode_ar = 1'b0;
    rnd_words(2, 2);
    m_load(DW'($urandom));
    for (int s = 0; s < 3; s++) begin
      repeat (int'($urandom_range(3, 0))) m_rw(1'b0, 1'b0);
      m_rw(1'b1, 1'b0);
      m_step(1'b0, s == 1);
    end
    repeat (8) m_rw(1'b0, 1'b0);
    play();
    foreach (tl[i]) begin
      tests++;
      if (obs[i] !== tl[i].ex) begin
        fails++;
        $display("FAIL single_step cyc %0d: got %h want %h", i, obs[i],
                 tl[i].ex);
      end
    end
    last = obs.size() - 1;
    tests++;
    if (pulses(done_at()) != 3 || obs[last][SW-1:0] !== SW'(3)) begin
      fails++;
      $display("FAIL single_step_total: pulses=%0d count=%0d want 3 3",
               pulses(done_at()), obs[last][SW-1:0]);
    end
  endtask

  task automatic test_timeout();
    int last;
    do_reset();
    mode_ar = 1'b1;
    rnd_words(2, 1);
    m_load(DW'($urandom));
    m_auto(-1);
    play();
    foreach (tl[i]) begin
      tests++;
      if (obs[i] !== tl[i].ex) begin
        fails++;
        $display("FAIL timeout cyc %0d: got %h want %h", i, obs[i],
                 tl[i].ex);
      end
    end
    last = obs.size() - 1;
    tests++;
    if (obs[last][SW-1:0] !== SW'(MAXS) || obs[last][TO] !== 1'b1 ||
        obs[last][BZ] !== 1'b0 || obs[last][FIN] !== 1'b0) begin
      fails++;
      $display("FAIL timeout_final: count=%0d to=%b busy=%b fin=%b",
               obs[last][SW-1:0], obs[last][TO], obs[last][BZ],
               obs[last][FIN]);
    end
    Reset = 1'b1;
    #1;
    tests++;
    if (step_count !== '0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_reset: count=%0d to=%b want 0 0",
               step_count, timeout);
    end
    Reset = 1'b0;
  endtask

  task automatic test_random_sessions();
    int h;
    for (int s = 0; s < 4; s++) begin
      do_reset();
      mode_ar = 1'b1;
      rnd_words(int'($urandom_range(4, 1)), 2);
      m_load(DW'($urandom));
      h = int'($urandom_range(MAXS + 1, 0));
      m_auto(h > MAXS ? -1 : h);
      play();
      foreach (tl[i]) begin
        tests++;
        if (obs[i] !== tl[i].ex) begin
          fails++;
          $display("FAIL rand_s%0d cyc %0d: got %h want %h", s, i, obs[i],
                   tl[i].ex);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_word();
    test_stream_stall();
    test_auto_halt();
    test_single_step();
    test_timeout();
    test_random_sessions();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
